imem_responder: RTL and testbench

Instruction-memory responder on the far side of the program-counter address interface. It accepts the 10-bit instruction address and read strobe, and returns the addressed instruction word with a fixed one-cycle latency and a valid pulse. It also contains a sequential program-load port that fills the memory before execution; a small state machine arbitrates between loading and serving fetches. It sits between the PC (address driver) and the decode/control unit (instruction consumer).

---
 rtl/imem_responder.sv | 111 +++++++++++
 tb/tb_imem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory with sequential program load and 1-cycle fetch port
module imem_responder #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 1024
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  im_addr,
    input  logic               im_r,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               oob,
    output logic               busy,
    output logic [ADDR_W:0]    prog_len
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [INSTR_W-1:0]  r_mem [DEPTH];
    logic                w_accept;
    logic                w_load_done;
    logic                w_fetch;
    logic                w_in_range;

    assign w_in_range = ({1'b0, im_addr} < prog_len);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ld_start outranks both a load word and a fetch presented on the same edge
    always_comb begin
        w_next_state = r_state;
        ld_ready     = 1'b0;
        busy         = 1'b1;
        w_accept     = 1'b0;
        w_load_done  = 1'b0;
        w_fetch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ld_start) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (!ld_start && ld_valid) begin
                    w_accept = 1'b1;
                    if (ld_last || (r_wr_ptr == LAST_ADDR)) begin
                        w_load_done  = 1'b1;
                        w_next_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b0;
                if (ld_start) begin
                    w_next_state = S_LOAD;
                end else if (im_r) begin
                    w_fetch = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (!rst && w_accept) begin
            r_mem[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            prog_len    <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            oob         <= 1'b0;
        end else begin
            if (ld_start) begin
                r_wr_ptr <= '0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (w_load_done) begin
                prog_len <= {1'b0, r_wr_ptr} + {{ADDR_W{1'b0}}, 1'b1};
            end
            instr_valid <= w_fetch;
            oob         <= w_fetch && !w_in_range;
            if (w_fetch) begin
                instr_out <= w_in_range ? r_mem[im_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed and randomized check of imem_responder against a behavioural model
module tb_imem_responder;

    logic        clock;
    logic        rst;
    logic [9:0]  im_addr;
    logic        im_r;
    logic        ld_start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        oob;
    logic        busy;
    logic [10:0] prog_len;

    imem_responder #(.ADDR_W(10), .INSTR_W(32), .DEPTH(1024)) dut (
        .clock       (clock),
        .rst         (rst),
        .im_addr     (im_addr),
        .im_r        (im_r),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .oob         (oob),
        .busy        (busy),
        .prog_len    (prog_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = loading, 2 = running
    int          m_mode = 0;
    int          m_wr = 0;
    int          m_len = 0;
    logic [31:0] m_mem [1024];
    logic [31:0] m_out = 0;
    bit          m_valid = 0;
    bit          m_oob = 0;
    bit          started = 0;

    always @(posedge clock) begin
        if (rst) begin
            m_mode = 0; m_wr = 0; m_len = 0;
            m_out = 0; m_valid = 0; m_oob = 0;
            started = 1;
        end else begin
            m_valid = 0;
            m_oob = 0;
            if (ld_start) begin
                m_mode = 1;
                m_wr = 0;
            end else if (m_mode == 1 && ld_valid) begin
                m_mem[m_wr] = ld_data;
                m_wr = m_wr + 1;
                if (ld_last || m_wr == 1024) begin
                    m_len = m_wr;
                    m_mode = 2;
                end
            end else if (m_mode == 2 && im_r) begin
                m_valid = 1;
                if (int'(im_addr) < m_len) begin
                    m_out = m_mem[im_addr];
                end else begin
                    m_out = 0;
                    m_oob = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("instr_valid", {63'd0, instr_valid}, {63'd0, m_valid});
            check("instr_out", {32'd0, instr_out}, {32'd0, m_out});
            check("oob", {63'd0, oob}, {63'd0, m_oob});
            check("busy", {63'd0, busy}, {63'd0, (m_mode != 2)});
            check("ld_ready", {63'd0, ld_ready}, {63'd0, (m_mode == 1)});
            check("prog_len", {53'd0, prog_len}, 64'(m_len));
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic quiet();
        ld_start = 0; ld_valid = 0; ld_last = 0; im_r = 0;
    endtask

    task automatic pulse_start();
        quiet();
        ld_start = 1;
        cyc();
        ld_start = 0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1; ld_data = d; ld_last = last;
        cyc();
        ld_valid = 0; ld_last = 0;
    endtask

    task automatic fetch(input logic [9:0] a, input logic [31:0] exp, input logic exp_oob, input string name);
        im_r = 1; im_addr = a;
        cyc();
        check({name, "_valid"}, {63'd0, instr_valid}, 64'd1);
        check({name, "_data"}, {32'd0, instr_out}, {32'd0, exp});
        check({name, "_oob"}, {63'd0, oob}, {63'd0, exp_oob});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        rst = 1; im_addr = 0; ld_data = 0;
        quiet();
        @(negedge clock);
        cyc();
        rst = 0;

        im_r = 1; im_addr = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_busy", {63'd0, busy}, 64'd1);
            check("rst_valid", {63'd0, instr_valid}, 64'd0);
            check("rst_out", {32'd0, instr_out}, 64'd0);
            check("rst_len", {53'd0, prog_len}, 64'd0);
        end

        pulse_start();
        load_word(32'h11, 0);
        load_word(32'h22, 0);
        load_word(32'h33, 0);
        load_word(32'h44, 1);
        check("load4_len", {53'd0, prog_len}, 64'd4);
        check("load4_busy", {63'd0, busy}, 64'd0);
        check("load4_ready", {63'd0, ld_ready}, 64'd0);
        fetch(0, 32'h11, 0, "f0");
        fetch(1, 32'h22, 0, "f1");
        fetch(2, 32'h33, 0, "f2");
        fetch(3, 32'h44, 0, "f3");
        quiet();

        pulse_start();
        load_word(32'h55, 0); cyc(); cyc();
        load_word(32'h66, 0); cyc(); cyc();
        load_word(32'h77, 1);
        check("gap_len", {53'd0, prog_len}, 64'd3);
        fetch(0, 32'h55, 0, "g0");
        fetch(1, 32'h66, 0, "g1");
        fetch(2, 32'h77, 0, "g2");
        quiet();

        pulse_start();
        load_word(32'h11, 0);
        load_word(32'h22, 0);
        load_word(32'h33, 0);
        load_word(32'h44, 1);
        fetch(4, 32'h0, 1, "oob4");
        fetch(1023, 32'h0, 1, "oob1023");
        fetch(2, 32'h33, 0, "in2");
        quiet();

        pulse_start();
        for (int i = 0; i < 1024; i++) load_word(32'(i), 0);
        check("full_len", {53'd0, prog_len}, 64'd1024);
        check("full_busy", {63'd0, busy}, 64'd0);
        fetch(1023, 32'd1023, 0, "full1023");
        fetch(517, 32'd517, 0, "full517");

        ld_start = 1; im_r = 1; im_addr = 5;
        cyc();
        quiet();
        check("restart_valid", {63'd0, instr_valid}, 64'd0);
        check("restart_ready", {63'd0, ld_ready}, 64'd1);
        check("restart_len", {53'd0, prog_len}, 64'd1024);
        load_word(32'hAA, 0);
        load_word(32'hBB, 1);
        check("reload_len", {53'd0, prog_len}, 64'd2);
        fetch(1, 32'hBB, 0, "rl1");
        fetch(2, 32'h0, 1, "rl2");
        quiet();
        pulse_start();
        load_word(32'hCC, 0);
        rst = 1;
        cyc();
        rst = 0;
        check("midrst_busy", {63'd0, busy}, 64'd1);
        check("midrst_ready", {63'd0, ld_ready}, 64'd0);
        check("midrst_len", {53'd0, prog_len}, 64'd0);
        check("midrst_valid", {63'd0, instr_valid}, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            ld_start = ($urandom_range(0, 39) == 0);
            ld_valid = ($urandom_range(0, 9) < 6);
            ld_data  = $urandom;
            ld_last  = ($urandom_range(0, 9) == 0);
            im_r     = ($urandom_range(0, 9) < 7);
            im_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
            cyc();
        end
        rst = 0;
        quiet();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
